// File: rtl/rs232_pkg.sv
// Shared FSM encoding and bit-period constants for the rs232_rx_fifo receiver (25 MHz clock).
package rs232_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_e;

    localparam int DIV_MIN    = 4;
    localparam int DIV_19200  = 1302;
    localparam int DIV_115200 = 217;

endpackage

// File: rtl/rs232_fifo.sv
// Synchronous first-word-fall-through FIFO; head word is driven to 0 while empty.
module rs232_fifo
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != FULL_CNT) || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: flops use non-blocking assignments so each one samples pre-edge values regardless of statement order.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage has no reset; it is only read behind count, so stale words are never visible.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);
    assign count = count_q;
    assign dout  = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/rs232_rx_fifo.sv
// RS232 receiver with runtime divisor, optional parity, sticky error flags and receive FIFO.
// Optional break detection (brk port, BREAK state) is enabled by defining RS232_RX_BREAK_EN.
module rs232_rx_fifo
    import rs232_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int DEPTH     = 16,
    parameter int DIV_W     = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rxd,
    input  logic [DIV_W-1:0]       div,
    input  logic                   par_en,
    input  logic                   par_odd,
    input  logic                   rd,
    output logic                   rdy,
    output logic [DATA_BITS-1:0]   data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   par_err,
    output logic                   frame_err,
    output logic                   overrun,
`ifdef RS232_RX_BREAK_EN
    output logic                   brk,
`endif
    input  logic                   err_clr
);

    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [DIV_W-1:0] DIV_FLOOR = DIV_W'(DIV_MIN);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);

    logic                 q0_q, q0_d, q1_q, q1_d;
    rx_state_e            state_q, state_d;
    logic [DIV_W-1:0]     div_l_q, div_l_d;
    logic [DIV_W-1:0]     tick_q, tick_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_bit_q, par_bit_d;
    logic                 par_err_q, par_err_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
    logic                 start_det, mid, wrap;
    logic                 push, par_evt, frame_evt, overrun_evt;
    logic                 fifo_full, fifo_empty, pop;
`ifdef RS232_RX_BREAK_EN
    logic                 brk_q, brk_d, brk_evt;
`endif

    always_comb begin
        q0_d        = rxd;
        q1_d        = q0_q;
        start_det   = q1_q & ~q0_q;
        wrap        = (tick_q == div_l_q - 1'b1);
        mid         = (tick_q == (div_l_q >> 1));
        state_d     = state_q;
        div_l_d     = div_l_q;
        tick_d      = wrap ? '0 : tick_q + 1'b1;
        bit_idx_d   = bit_idx_q;
        shreg_d     = shreg_q;
        par_bit_d   = par_bit_q;
        push        = 1'b0;
        par_evt     = 1'b0;
        frame_evt   = 1'b0;
`ifdef RS232_RX_BREAK_EN
        brk_evt     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                tick_d = '0;
                if (start_det) begin
                    state_d = START;
                    div_l_d = (div < DIV_FLOOR) ? DIV_FLOOR : div;
                end
            end
            START: begin
                if (mid && q1_q) begin
                    state_d = IDLE;
                end else if (wrap) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                if (mid) shreg_d = {q1_q, shreg_q[DATA_BITS-1:1]};
                if (wrap) begin
                    if (bit_idx_q == LAST_IDX) state_d = par_en ? PARITY : STOP;
                    else                       bit_idx_d = bit_idx_q + 1'b1;
                end
            end
            PARITY: begin
                if (mid)  par_bit_d = q1_q;
                if (wrap) state_d   = STOP;
            end
            STOP: begin
                // Re-arm at mid-stop so a sender running slightly fast is not missed.
                if (mid) begin
                    state_d = IDLE;
                    if (!q1_q) begin
`ifdef RS232_RX_BREAK_EN
                        if ((shreg_q == '0) && (!par_en || !par_bit_q)) begin
                            brk_evt = 1'b1;
                            state_d = BREAK;
                        end else begin
                            frame_evt = 1'b1;
                        end
`else
                        frame_evt = 1'b1;
`endif
                    end else if (par_en && ((^shreg_q ^ par_bit_q) != par_odd)) begin
                        par_evt = 1'b1;
                    end else begin
                        push = 1'b1;
                    end
                end
            end
            BREAK: begin
                tick_d = '0;
                if (q1_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A pop frees the slot on the same edge, so a push into a full FIFO with rd is not an overrun.
    assign pop         = rd && !fifo_empty;
    assign overrun_evt = push && fifo_full && !rd;

    always_comb begin
        par_err_d   = err_clr ? 1'b0 : par_err_q;
        frame_err_d = err_clr ? 1'b0 : frame_err_q;
        overrun_d   = err_clr ? 1'b0 : overrun_q;
        if (par_evt)     par_err_d   = 1'b1;
        if (frame_evt)   frame_err_d = 1'b1;
        if (overrun_evt) overrun_d   = 1'b1;
`ifdef RS232_RX_BREAK_EN
        brk_d = err_clr ? 1'b0 : brk_q;
        if (brk_evt) brk_d = 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q0_q        <= 1'b1;
            q1_q        <= 1'b1;
            state_q     <= IDLE;
            div_l_q     <= DIV_FLOOR;
            tick_q      <= '0;
            bit_idx_q   <= '0;
            shreg_q     <= '0;
            par_bit_q   <= 1'b0;
            par_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef RS232_RX_BREAK_EN
            brk_q       <= 1'b0;
`endif
        end else begin
            q0_q        <= q0_d;
            q1_q        <= q1_d;
            state_q     <= state_d;
            div_l_q     <= div_l_d;
            tick_q      <= tick_d;
            bit_idx_q   <= bit_idx_d;
            shreg_q     <= shreg_d;
            par_bit_q   <= par_bit_d;
            par_err_q   <= par_err_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
`ifdef RS232_RX_BREAK_EN
            brk_q       <= brk_d;
`endif
        end
    end

    rs232_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (shreg_q),
        .pop   (pop),
        .dout  (data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (count)
    );

    assign rdy       = !fifo_empty;
    assign par_err   = par_err_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
`ifdef RS232_RX_BREAK_EN
    assign brk       = brk_q;
`endif

endmodule

// File: tb/tb_rs232_rx_fifo.sv
// Directed and randomized frames against a queue-based model of the receiver and its FIFO.
module tb_rs232_rx_fifo;
    import rs232_pkg::*;

    localparam int DEPTH = 16;

    logic        clk;
    logic        rst;
    logic        rxd;
    logic [11:0] div;
    logic        par_en;
    logic        par_odd;
    logic        rd;
    logic        rdy;
    logic [7:0]  data;
    logic [4:0]  count;
    logic        par_err;
    logic        frame_err;
    logic        overrun;
    logic        err_clr;
`ifdef RS232_RX_BREAK_EN
    logic        brk;
`endif

    rs232_rx_fifo #(
        .DATA_BITS (8),
        .DEPTH     (DEPTH),
        .DIV_W     (12)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rxd       (rxd),
        .div       (div),
        .par_en    (par_en),
        .par_odd   (par_odd),
        .rd        (rd),
        .rdy       (rdy),
        .data      (data),
        .count     (count),
        .par_err   (par_err),
        .frame_err (frame_err),
        .overrun   (overrun),
`ifdef RS232_RX_BREAK_EN
        .brk       (brk),
`endif
        .err_clr   (err_clr)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model: expected FIFO contents and sticky flags.
    logic [7:0] model_q [$];
    logic       exp_par, exp_frame, exp_ovr, exp_brk;
    int         eff_div;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_div(input int d);
        div     = 12'(d);
        eff_div = (d < DIV_MIN) ? DIV_MIN : d;
    endtask

    function automatic logic good_parity(input logic [7:0] d);
        // Parity bit that makes the total count of ones odd (par_odd=1) or even (par_odd=0).
        return (($countones(d) % 2) == 1) ? ~par_odd : par_odd;
    endfunction

    task automatic model_frame(input logic [7:0] d, input logic pb, input logic sb);
        if (!sb) begin
`ifdef RS232_RX_BREAK_EN
            if (d == 8'h00 && (!par_en || !pb)) exp_brk = 1'b1;
            else exp_frame = 1'b1;
`else
            exp_frame = 1'b1;
`endif
        end else if (par_en && ((($countones(d) + int'(pb)) % 2) != int'(par_odd))) begin
            exp_par = 1'b1;
        end else if (model_q.size() >= DEPTH) begin
            exp_ovr = 1'b1;
        end else begin
            model_q.push_back(d);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pb, input logic sb);
        rxd = 1'b0;
        cycles(eff_div);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            cycles(eff_div);
        end
        if (par_en) begin
            rxd = pb;
            cycles(eff_div);
        end
        rxd = sb;
        cycles(eff_div);
        rxd = 1'b1;
        cycles(2);
        model_frame(d, pb, sb);
    endtask

    task automatic do_read();
        rd = 1'b1;
        cycles(1);
        rd = 1'b0;
        if (model_q.size() != 0) void'(model_q.pop_front());
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        cycles(1);
        err_clr = 1'b0;
        exp_par   = 1'b0;
        exp_frame = 1'b0;
        exp_ovr   = 1'b0;
        exp_brk   = 1'b0;
    endtask

    task automatic check_state(input string tag);
        logic [7:0] head;
        head = (model_q.size() != 0) ? model_q[0] : 8'h00;
        check({tag, ".rdy"},       32'(rdy),       32'(model_q.size() != 0));
        check({tag, ".count"},     32'(count),     32'(model_q.size()));
        check({tag, ".data"},      32'(data),      32'(head));
        check({tag, ".par_err"},   32'(par_err),   32'(exp_par));
        check({tag, ".frame_err"}, 32'(frame_err), 32'(exp_frame));
        check({tag, ".overrun"},   32'(overrun),   32'(exp_ovr));
`ifdef RS232_RX_BREAK_EN
        check({tag, ".brk"},       32'(brk),       32'(exp_brk));
`endif
    endtask

    initial begin
        #(64'd40 * 64'd150000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] d;
        logic       pb, sb;

        rst = 1'b1; rxd = 1'b1; par_en = 1'b0; par_odd = 1'b0;
        rd = 1'b0; err_clr = 1'b0;
        exp_par = 1'b0; exp_frame = 1'b0; exp_ovr = 1'b0; exp_brk = 1'b0;
        set_div(DIV_115200);
        cycles(3);
        check_state("reset");
        rst = 1'b0;
        cycles(4);

        // 8N1 0xA5 at 115200: rdy rises exactly one cycle after the stop sample.
        d = 8'hA5;
        rxd = 1'b0;
        cycles(eff_div);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            cycles(eff_div);
        end
        rxd = 1'b1;
        cycles(3 + eff_div / 2 - 1);
        check("lat.before_stop", 32'(rdy), 32'd0);
        cycles(1);
        model_frame(d, 1'b0, 1'b1);
        check_state("lat.after_stop");
        cycles(eff_div - (3 + eff_div / 2) + 2);
        do_read();
        check_state("lat.read");

        // Even parity at 19200: correct parity accepted, wrong parity rejected.
        set_div(DIV_19200);
        par_en = 1'b1; par_odd = 1'b0;
        send_frame(8'h07, 1'b1, 1'b1);
        check_state("par.good");
        send_frame(8'h07, 1'b0, 1'b1);
        check_state("par.bad");
        do_read();
        pulse_clr();
        par_en = 1'b0;

        // 3-cycle glitch is a false start; a frame right after it must still be received.
        set_div(DIV_115200);
        rxd = 1'b0;
        cycles(3);
        rxd = 1'b1;
        cycles(eff_div / 2 + 8);
        check_state("glitch.none");
        send_frame(8'h5A, 1'b0, 1'b1);
        check_state("glitch.next");
        do_read();

        // Stop bit low: framing error, nothing pushed; err_clr clears it.
        send_frame(8'h3C, 1'b0, 1'b0);
        check_state("frame.err");
        pulse_clr();
        check("frame.cleared", 32'(frame_err), 32'd0);

        // Seventeen bytes without reading: FIFO full plus overrun, then in-order readback.
        set_div(20);
        for (int i = 0; i <= 16; i++) send_frame(8'(i), 1'b0, 1'b1);
        check_state("ovr.full");
        for (int i = 0; i < 16; i++) begin
            check("ovr.order", 32'(data), 32'(i));
            do_read();
        end
        check_state("ovr.drained");
        pulse_clr();

        // Full FIFO, rd on the push edge: slot freed, no overrun, newest entry at the tail.
        for (int i = 0; i < 16; i++) send_frame(8'(i), 1'b0, 1'b1);
        d = 8'h10;
        rxd = 1'b0;
        cycles(eff_div);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            cycles(eff_div);
        end
        rxd = 1'b1;
        cycles(3 + eff_div / 2 - 1);
        rd = 1'b1;
        cycles(1);
        rd = 1'b0;
        void'(model_q.pop_front());
        model_frame(d, 1'b0, 1'b1);
        check_state("fullrd.push");
        cycles(eff_div - (3 + eff_div / 2) + 2);
        for (int i = 0; i < 15; i++) do_read();
        check("fullrd.newest", 32'(data), 32'h10);
        check_state("fullrd.tail");

        // Reset mid-frame with flags set: everything clears, next frame is received.
        send_frame(8'h99, 1'b0, 1'b0);
        rxd = 1'b0;
        cycles(3 * eff_div);
        rst = 1'b1;
        rxd = 1'b1;
        cycles(1);
        model_q.delete();
        exp_par = 1'b0; exp_frame = 1'b0; exp_ovr = 1'b0; exp_brk = 1'b0;
        check_state("rst.mid");
        rst = 1'b0;
        cycles(3);
        send_frame(8'hC3, 1'b0, 1'b1);
        check_state("rst.after");
        do_read();

        // Randomized frames: divisor (including below the floor), parity mode, errors, reads.
        for (int n = 0; n < 40; n++) begin
            set_div($urandom_range(1, 40));
            par_en  = 1'($urandom_range(0, 1));
            par_odd = 1'($urandom_range(0, 1));
            d  = 8'($urandom);
            pb = ($urandom_range(0, 4) != 0) ? good_parity(d) : ~good_parity(d);
            sb = ($urandom_range(0, 9) != 0);
            send_frame(d, pb, sb);
            check_state("rand.frame");
            if ($urandom_range(0, 2) == 0) begin
                do_read();
                check_state("rand.read");
            end
            if ($urandom_range(0, 3) == 0) begin
                pulse_clr();
                check_state("rand.clr");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
